// File: rtl/div_pkg.sv
// Shared encodings and constants for the sequential 32-bit divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // bit 0 clear -> signed op (DIV/REM)
  function automatic logic op_signed(op_e op);
    return ~op[0];
  endfunction

  // bit 1 set -> remainder requested
  function automatic logic op_rem(op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div32b_seq_if.sv
// Request/response handshake bundle for div32b_seq.
interface div32b_seq_if;
  import div_pkg::*;

  logic                 i_valid;
  logic                 o_ready;
  logic [1:0]           i_op;
  logic [DIV_WIDTH-1:0] i_dividend;
  logic [DIV_WIDTH-1:0] i_divisor;
  logic                 i_flush;
  logic                 o_valid;
  logic                 i_resp_ready;
  logic [DIV_WIDTH-1:0] o_result;

  // divider side
  modport slave (
    input  i_valid, i_op, i_dividend, i_divisor, i_flush, i_resp_ready,
    output o_ready, o_valid, o_result
  );

  // pipeline side
  modport master (
    output i_valid, i_op, i_dividend, i_divisor, i_flush, i_resp_ready,
    input  o_ready, o_valid, o_result
  );
endinterface

// File: rtl/div32b_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
module div32b_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH:0]   i_rem,
  input  logic                 i_dvd_msb,
  input  logic [DIV_WIDTH-1:0] i_dvs,
  output logic [DIV_WIDTH:0]   o_next_rem,
  output logic                 o_q_bit
);

  logic [DIV_WIDTH:0] w_rem_t;

  assign w_rem_t = {i_rem[DIV_WIDTH-1:0], i_dvd_msb};
  // partial remainder stays below the divisor, so i_rem[32] is zero in
  // practice; honouring it keeps the step correct on its own terms
  assign o_q_bit    = i_rem[DIV_WIDTH] | (w_rem_t >= {1'b0, i_dvs});
  assign o_next_rem = o_q_bit ? (w_rem_t - {1'b0, i_dvs}) : w_rem_t;

endmodule

// File: rtl/div32b_seq.sv
// Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional feature macro: DIV_SPECIAL_FAST_EN -- divide-by-zero and signed
// overflow complete at the accept edge instead of running the full loop.
module div32b_seq
  import div_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  div32b_seq_if.slave  bus
);

  state_e                r_state, w_next;
  op_e                   r_op;
  logic                  r_neg_q, r_neg_r;
  logic [DIV_WIDTH-1:0]  r_dvd, r_dvs, r_result;
  logic [DIV_WIDTH:0]    r_rem;
  logic [4:0]            r_cnt;
  logic                  r_valid;
`ifndef DIV_SPECIAL_FAST_EN
  logic                  r_spec;
  logic [DIV_WIDTH-1:0]  r_spec_res;
`endif

  op_e                   w_op;
  logic                  w_accept, w_sgn, w_div0, w_ovf, w_spec, w_q_bit;
  logic [DIV_WIDTH-1:0]  w_spec_res, w_abs_dvd, w_abs_dvs, w_q_out, w_r_out, w_fix_res;
  logic [DIV_WIDTH:0]    w_next_rem;

  // flush has priority, so a request arriving with it is dropped
  assign w_accept = bus.i_valid & (r_state == ST_IDLE) & ~bus.i_flush;
  assign w_op     = op_e'(bus.i_op);
  assign w_sgn    = op_signed(w_op);
  assign w_div0   = (bus.i_divisor == '0);
  assign w_ovf    = w_sgn & (bus.i_dividend == 32'h8000_0000) & (bus.i_divisor == '1);
  assign w_spec   = w_div0 | w_ovf;

  // RISC-V results for the two special cases
  assign w_spec_res = w_div0 ? (op_rem(w_op) ? bus.i_dividend : '1)
                             : (op_rem(w_op) ? '0 : 32'h8000_0000);

  // magnitudes only for signed ops; unsigned operands pass through
  assign w_abs_dvd = (op_signed(r_op) & r_dvd[31]) ? (~r_dvd + 32'd1) : r_dvd;
  assign w_abs_dvs = (op_signed(r_op) & r_dvs[31]) ? (~r_dvs + 32'd1) : r_dvs;

  div32b_step u_step (
    .i_rem      (r_rem),
    .i_dvd_msb  (r_dvd[DIV_WIDTH-1]),
    .i_dvs      (r_dvs),
    .o_next_rem (w_next_rem),
    .o_q_bit    (w_q_bit)
  );

  // after the loop r_dvd holds the quotient and r_rem the remainder
  assign w_q_out = r_neg_q ? (~r_dvd + 32'd1) : r_dvd;
  assign w_r_out = r_neg_r ? (~r_rem[DIV_WIDTH-1:0] + 32'd1) : r_rem[DIV_WIDTH-1:0];

  // final result select, with the special result overriding the loop output
  always_comb begin
    w_fix_res = op_rem(r_op) ? w_r_out : w_q_out;
`ifndef DIV_SPECIAL_FAST_EN
    if (r_spec) w_fix_res = r_spec_res;
`endif
  end

  // next-state logic; flush returns to IDLE from anywhere
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) begin
`ifdef DIV_SPECIAL_FAST_EN
        w_next = w_spec ? ST_DONE : ST_PREP;
`else
        w_next = ST_PREP;
`endif
      end
      ST_PREP: w_next = ST_CALC;
      ST_CALC: if (r_cnt == 5'(DIV_ITER - 1)) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: if (bus.i_resp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (bus.i_flush) w_next = ST_IDLE;
  end

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // datapath: operand latch, prep, iteration, result and valid
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op       <= OP_DIV;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_valid    <= 1'b0;
`ifndef DIV_SPECIAL_FAST_EN
      r_spec     <= 1'b0;
      r_spec_res <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op    <= w_op;
          r_neg_q <= w_sgn & (bus.i_dividend[31] ^ bus.i_divisor[31]);
          r_neg_r <= w_sgn & bus.i_dividend[31];
          r_dvd   <= bus.i_dividend;
          r_dvs   <= bus.i_divisor;
`ifdef DIV_SPECIAL_FAST_EN
          if (w_spec) begin
            r_result <= w_spec_res;
            r_valid  <= 1'b1;
          end
`else
          r_spec     <= w_spec;
          r_spec_res <= w_spec_res;
`endif
        end
        ST_PREP: begin
          r_dvd <= w_abs_dvd;
          r_dvs <= w_abs_dvs;
          r_rem <= '0;
          r_cnt <= '0;
        end
        ST_CALC: begin
          r_rem <= w_next_rem;
          r_dvd <= {r_dvd[DIV_WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt + 5'd1;
        end
        ST_FIX: begin
          r_result <= w_fix_res;
          r_valid  <= 1'b1;
        end
        ST_DONE: if (bus.i_resp_ready) r_valid <= 1'b0;
        default: ;
      endcase
      if (bus.i_flush) r_valid <= 1'b0;
    end
  end

  assign bus.o_ready  = (r_state == ST_IDLE);
  assign bus.o_valid  = r_valid;
  assign bus.o_result = r_result;

endmodule

// File: tb/tb_div32b_seq.sv
// Self-checking bench for div32b_seq: directed table, handshake/flush/reset
// sequences, and random operations against an arithmetic reference.
module tb_div32b_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div32b_seq_if bif();

  div32b_seq u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bif)
  );

  // edges from the accept edge to the edge that registers o_valid;
  // the fast special path registers on the accept edge itself
`ifdef DIV_SPECIAL_FAST_EN
  localparam int SPL = 0;
`else
  localparam int SPL = 34;
`endif
  localparam int NRM = 34;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // plain-arithmetic reference following the RISC-V M rules
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn, rem;
    sgn = ~op[0];
    rem = op[1];
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
      return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return rem ? a % b : a / b;
  endfunction

  // issue one request from idle and wait for the result
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(posedge clk); #1;
    bif.i_valid = 1'b1; bif.i_op = op; bif.i_dividend = a; bif.i_divisor = b;
    @(posedge clk); #1;
    bif.i_valid = 1'b0;
    lat = 0;
    while (!bif.o_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bif.o_valid) begin
      n_chk++; n_err++;
      $display("FAIL timeout: no o_valid within %0d cycles, required a result", lat);
    end
    res = bif.o_result;
  endtask

  // watch n cycles and return how many had o_valid high
  task automatic watch_valid(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (bif.o_valid) seen++;
    end
  endtask

  initial begin
    logic [31:0] res, held, a, b;
    logic [1:0]  op;
    int lat, seen, sel;

    bif.i_valid = 1'b0; bif.i_op = 2'b00; bif.i_dividend = '0; bif.i_divisor = '0;
    bif.i_flush = 1'b0; bif.i_resp_ready = 1'b1;

    tbl[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         NRM};
    tbl[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          NRM};
    tbl[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  NRM};
    tbl[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  NRM};
    tbl[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          NRM};
    tbl[5]  = '{2'b01, 32'h1234,       32'd0,          32'hFFFF_FFFF,  SPL};
    tbl[6]  = '{2'b11, 32'h1234,       32'd0,          32'h1234,       SPL};
    tbl[7]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  SPL};
    tbl[8]  = '{2'b10, 32'd5,          32'd0,          32'd5,          SPL};
    tbl[9]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  SPL};
    tbl[10] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          SPL};
    tbl[11] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          NRM};
    tbl[12] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  NRM};

    // reset state
    #1;
    chk("rst_ready",  bif.o_ready,  1'b1);
    chk("rst_valid",  bif.o_valid,  1'b0);
    chk("rst_result", bif.o_result, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // directed table
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
      chk($sformatf("vec%0d_res", i), res, tbl[i].exp);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
    end

    // consumer stalls for 5 cycles: outputs hold, no new request taken
    @(posedge clk); #1;
    bif.i_resp_ready = 1'b0;
    run_op(2'b01, 32'd1000, 32'd9, res, lat);
    chk("hold_res0", res, 32'd111);
    held = res;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_valid%0d", k), bif.o_valid, 1'b1);
      chk($sformatf("hold_res%0d", k + 1), bif.o_result, held);
      chk($sformatf("hold_ready%0d", k), bif.o_ready, 1'b0);
    end
    bif.i_resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("accept_valid", bif.o_valid, 1'b0);
    chk("accept_ready", bif.o_ready, 1'b1);

    // flush in the middle of the iteration loop
    bif.i_valid = 1'b1; bif.i_op = 2'b01; bif.i_dividend = 32'd1000; bif.i_divisor = 32'd7;
    @(posedge clk); #1;
    bif.i_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1 bif.i_flush = 1'b1;
    @(posedge clk); #1;
    bif.i_flush = 1'b0;
    chk("flush_ready", bif.o_ready, 1'b1);
    watch_valid(40, seen);
    chk("flush_no_valid", seen, 0);
    run_op(2'b01, 32'd9, 32'd3, res, lat);
    chk("post_flush_res", res, 32'd3);

    // flush and request on the same edge: request is dropped
    @(posedge clk); #1;
    bif.i_valid = 1'b1; bif.i_flush = 1'b1; bif.i_op = 2'b01;
    bif.i_dividend = 32'd50; bif.i_divisor = 32'd5;
    @(posedge clk); #1;
    bif.i_valid = 1'b0; bif.i_flush = 1'b0;
    chk("flush_acc_ready", bif.o_ready, 1'b1);
    watch_valid(40, seen);
    chk("flush_acc_no_valid", seen, 0);

    // asynchronous reset mid-loop
    @(posedge clk); #1;
    bif.i_valid = 1'b1; bif.i_op = 2'b01; bif.i_dividend = 32'd1000; bif.i_divisor = 32'd7;
    @(posedge clk); #1;
    bif.i_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready",  bif.o_ready,  1'b1);
    chk("midrst_valid",  bif.o_valid,  1'b0);
    chk("midrst_result", bif.o_result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b01, 32'd9, 32'd3, res, lat);
    chk("post_rst_res", res, 32'd3);

    // random operations against the reference
    for (int k = 0; k < 60; k++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: begin a = 32'($urandom_range(0, 200)); b = $urandom; end
        4: b = {1'b1, 31'($urandom)};
        default: b = $urandom;
      endcase
      run_op(op, a, b, res, lat);
      chk($sformatf("rnd%0d_res op%0d %h/%h", k, op, a, b), res, ref_res(op, a, b));
      chk($sformatf("rnd%0d_lat", k), lat, is_special(op, a, b) ? SPL : NRM);
    end

    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
